// File: rtl/tx_ctrl_pkg.sv
// Shared types and helpers for the transmit shift-register sequencing controller.
package tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_period_timer.sv
// Tick counter (clocks within a bit) and bit counter (bits within a byte).
// clear wins over enable; both counters wrap to zero after the final slot.
module bit_period_timer
  import tx_ctrl_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int BIT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick,
  output logic final_slot
);

  localparam int TICK_W = cnt_width(BIT_PERIOD);
  localparam int BIT_W  = cnt_width(NUM_BITS);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(BIT_PERIOD - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(NUM_BITS - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;

  assign bit_tick   = enable && (tick_cnt == TICK_MAX);
  assign final_slot = bit_tick && (bit_cnt == BIT_MAX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (tick_cnt == TICK_MAX) begin
        tick_cnt <= '0;
        bit_cnt  <= (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_shift_ctrl.sv
// Sequences load/shift strobes for the parallel-to-serial transmit shifter,
// with a one-byte holding register so multi-byte frames go out gaplessly.
module tx_shift_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int BIT_PERIOD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                byte_valid,
  input  logic [NUM_BITS-1:0] byte_data,
  input  logic                byte_last,
  output logic                byte_ready,
  output logic                load_enable,
  output logic                shift_enable,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic                busy,
  output logic                tx_done,
  output logic                underrun,
  output tx_state_t           dbg_state
);

  // Handshake: a byte transfers on every rising edge where byte_valid && byte_ready.
  // byte_ready is a register (!hold_full), never a function of byte_valid; the
  // producer keeps data/last stable while byte_valid && !byte_ready.

  tx_state_t           state;
  tx_state_t           state_next;
  logic [NUM_BITS-1:0] hold;
  logic                hold_full;
  logic                hold_last;
  logic                cur_last;
  logic                accept;
  logic                bit_tick;
  logic                final_slot;
  logic                timer_enable;

  assign accept       = byte_valid && !hold_full;
  assign byte_ready   = !hold_full;
  assign timer_enable = (state == SHIFT);
  assign busy         = (state != IDLE);
  assign parallel_out = load_enable ? hold : '0;
  assign dbg_state    = state;

  bit_period_timer #(
    .NUM_BITS   (NUM_BITS),
    .BIT_PERIOD (BIT_PERIOD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_enable),
    .enable     (timer_enable),
    .bit_tick   (bit_tick),
    .final_slot (final_slot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // IDLE also reacts to a byte being accepted this cycle so the load follows
  // acceptance by exactly one clock.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hold_full || accept) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT: begin
        if (final_slot) begin
          if (cur_last)        state_next = DONE;
          else if (!hold_full) state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // In the final slot of a non-last byte a buffered byte replaces the last shift.
  always_comb begin
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    tx_done      = 1'b0;
    underrun     = 1'b0;
    case (state)
      LOAD: load_enable = 1'b1;
      SHIFT: begin
        if (bit_tick) begin
          if (final_slot && !cur_last && hold_full) begin
            load_enable = 1'b1;
          end else begin
            shift_enable = 1'b1;
          end
          if (final_slot && !cur_last && !hold_full) begin
            underrun = 1'b1;
          end
        end
      end
      DONE:    tx_done = 1'b1;
      default: ;
    endcase
  end

  // A load can only happen while hold_full is set, so load and accept never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      cur_last  <= 1'b0;
    end else if (load_enable) begin
      hold_full <= 1'b0;
      cur_last  <= hold_last;
    end else if (accept) begin
      hold      <= byte_data;
      hold_full <= 1'b1;
      hold_last <= byte_last;
    end
  end

endmodule

// File: tb/tb_tx_shift_ctrl.sv
// Directed scoreboard bench for tx_shift_ctrl with NUM_BITS=8, BIT_PERIOD=4.
module tb_tx_shift_ctrl;
  import tx_ctrl_pkg::*;

  localparam int EW = 29;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_last = 1'b0;
  logic       byte_ready;
  logic       load_enable;
  logic       shift_enable;
  logic [7:0] parallel_out;
  logic       busy;
  logic       tx_done;
  logic       underrun;
  tx_state_t  dbg_state;

  int cyc = 0;
  int base = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic [EW-1:0] exp_q[$];

  tx_shift_ctrl #(
    .NUM_BITS   (8),
    .BIT_PERIOD (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_last    (byte_last),
    .byte_ready   (byte_ready),
    .load_enable  (load_enable),
    .shift_enable (shift_enable),
    .parallel_out (parallel_out),
    .busy         (busy),
    .tx_done      (tx_done),
    .underrun     (underrun),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Event word: {cycle, accept, load, shift, done, underrun, data}
  function automatic logic [EW-1:0] ev(input int c, input logic acc, input logic ld,
                                       input logic sh, input logic dn, input logic ur,
                                       input logic [7:0] d);
    return {16'(c), acc, ld, sh, dn, ur, d};
  endfunction

  task automatic push_shifts(input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ev(first + 4 * i, 0, 0, 1, 0, 0, 8'h00));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base);
  endtask

  // Scoreboard monitor: every observed output event is popped against exp_q.
  logic          ev_acc;
  logic [EW-1:0] got;
  logic [EW-1:0] want;
  always @(negedge clk) begin
    if (!rst) begin
      ev_acc = byte_valid && byte_ready;
      if (ev_acc || load_enable || shift_enable || tx_done || underrun) begin
        got = ev(cyc - base, ev_acc, load_enable, shift_enable, tx_done, underrun,
                 ev_acc ? byte_data : parallel_out);
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL event_unexpected: got %h expected none", got);
        end else begin
          want = exp_q.pop_front();
          if (got === want) n_pass++;
          else $display("FAIL event: got %h expected %h", got, want);
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_to(input int c);
    while (cyc - base < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n, input logic valid_during);
    @(posedge clk);
    #1;
    rst = 1'b1;
    byte_valid = valid_during;
    byte_data = 8'hFF;
    byte_last = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    byte_valid = 1'b0;
    base = cyc;
  endtask

  task automatic send(input int c, input logic [7:0] d, input logic last);
    int budget;
    wait_to(c);
    byte_valid = 1'b1;
    byte_data = d;
    byte_last = last;
    budget = 0;
    while (!byte_ready && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (!byte_ready) begin
      n_checks++;
      $display("FAIL send_timeout: byte %h not accepted, ready %b expected 1", d, byte_ready);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_load"}, 32'(load_enable), 0);
    check({pfx, "_shift"}, 32'(shift_enable), 0);
    check({pfx, "_pout"}, 32'(parallel_out), 0);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_done"}, 32'(tx_done), 0);
    check({pfx, "_underrun"}, 32'(underrun), 0);
    check({pfx, "_ready"}, 32'(byte_ready), 1);
    check({pfx, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    // Reset held 3 cycles with a byte offered: nothing may be accepted.
    do_reset(3, 1'b1);
    check_idle("reset");
    wait_to(2);
    check("reset_no_accept_busy", 32'(busy), 0);
    check("reset_no_accept_state", 32'(dbg_state), 32'(IDLE));

    // Single byte
    do_reset(2, 1'b0);
    exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'hA5));
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 8'hA5));
    push_shifts(5, 8);
    exp_q.push_back(ev(34, 0, 0, 0, 1, 0, 8'h00));
    send(0, 8'hA5, 1'b1);
    wait_to(1);
    check("single_busy_load", 32'(busy), 1);
    wait_to(34);
    check("single_busy_done", 32'(busy), 1);
    wait_to(35);
    check("single_idle_after", 32'(busy), 0);
    wait_to(40);
    check("single_drain", 32'(exp_q.size()), 0);

    // Back-to-back frame with a third byte under backpressure
    do_reset(2, 1'b0);
    exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'h3C));
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 8'h3C));
    exp_q.push_back(ev(2, 1, 0, 0, 0, 0, 8'hC3));
    push_shifts(5, 7);
    exp_q.push_back(ev(33, 0, 1, 0, 0, 0, 8'hC3));
    exp_q.push_back(ev(34, 1, 0, 0, 0, 0, 8'h96));
    push_shifts(37, 8);
    exp_q.push_back(ev(66, 0, 0, 0, 1, 0, 8'h00));
    exp_q.push_back(ev(68, 0, 1, 0, 0, 0, 8'h96));
    push_shifts(72, 8);
    exp_q.push_back(ev(101, 0, 0, 0, 1, 0, 8'h00));
    fork
      begin
        send(0, 8'h3C, 1'b0);
        send(1, 8'hC3, 1'b1);
        send(3, 8'h96, 1'b1);
      end
      begin
        wait_to(20);
        check("bp_ready_low", 32'(byte_ready), 0);
        wait_to(33);
        check("bp_ready_at_load", 32'(byte_ready), 0);
        check("b2b_busy_33", 32'(busy), 1);
        wait_to(34);
        check("bp_ready_after_load", 32'(byte_ready), 1);
        check("b2b_busy_34", 32'(busy), 1);
      end
    join
    wait_to(67);
    check("b2b_idle_67", 32'(busy), 0);
    wait_to(106);
    check("b2b_drain", 32'(exp_q.size()), 0);

    // Underrun: non-last byte with nothing buffered behind it
    do_reset(2, 1'b0);
    exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'h55));
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 8'h55));
    push_shifts(5, 7);
    exp_q.push_back(ev(33, 0, 0, 1, 0, 1, 8'h00));
    send(0, 8'h55, 1'b0);
    wait_to(34);
    check("underrun_state_idle", 32'(dbg_state), 32'(IDLE));
    check("underrun_busy", 32'(busy), 0);
    wait_to(40);
    check("underrun_drain", 32'(exp_q.size()), 0);

    // Reset mid-byte, then a fresh byte
    do_reset(2, 1'b0);
    exp_q.push_back(ev(0, 1, 0, 0, 0, 0, 8'hA5));
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 8'hA5));
    push_shifts(5, 3);
    exp_q.push_back(ev(17, 1, 0, 0, 0, 0, 8'h5A));
    exp_q.push_back(ev(18, 0, 1, 0, 0, 0, 8'h5A));
    push_shifts(22, 8);
    exp_q.push_back(ev(51, 0, 0, 0, 1, 0, 8'h00));
    send(0, 8'hA5, 1'b1);
    wait_to(15);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("midrst");
    send(17, 8'h5A, 1'b1);
    wait_to(56);
    check("midrst_drain", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
